// File: rtl/byte_lane_ram_pkg.sv
// Shared types for the byte-lane SRAM front-end: host op codes, FSM states,
// and grant owners.
package byte_lane_ram_pkg;

  typedef enum logic [1:0] {
    HOP_SETA  = 2'd0,
    HOP_WRITE = 2'd1,
    HOP_READ  = 2'd2,
    HOP_NOP   = 2'd3
  } host_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS_ACK,
    ST_HOST_ACK,
    ST_HOLD
  } ctrl_state_e;

  typedef enum logic {
    OWN_BUS  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/byte_lane_ram_arb.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module byte_lane_ram_arb
  import byte_lane_ram_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_bus,
  input  logic i_req_host,
  output logic o_gnt_bus,
  output logic o_gnt_host
);

  owner_e last_grant;

  always_comb begin
    o_gnt_bus  = i_en && i_req_bus && (!i_req_host || last_grant == OWN_HOST);
    o_gnt_host = i_en && i_req_host && !o_gnt_bus;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      last_grant <= OWN_HOST;
    end else if (o_gnt_bus) begin
      last_grant <= OWN_BUS;
    end else if (o_gnt_host) begin
      last_grant <= OWN_HOST;
    end
  end

endmodule

// File: rtl/byte_lane_ram_ctrl.sv
// Arbitrating front-end for a byte-write-enabled SRAM macro (host byte port + CPU bus).
// Define BYTE_LANE_RAM_CTRL_AUTOINC_EN to auto-increment the host pointer on WRITE/READ.
module byte_lane_ram_ctrl
  import byte_lane_ram_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH),
  parameter int LB         = $clog2(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_host_valid,
  input  logic [1:0]              i_host_op,
  input  logic [7:0]              i_host_data,
  output logic                    o_host_ready,
  output logic [7:0]              o_host_rdata,
  output logic                    o_host_rvalid,
  input  logic                    i_bus_cyc,
  input  logic                    i_bus_we,
  input  logic [AW-1:0]           i_bus_adr,
  input  logic [WORD_BYTES-1:0]   i_bus_sel,
  input  logic [8*WORD_BYTES-1:0] i_bus_dat,
  output logic [8*WORD_BYTES-1:0] o_bus_rdt,
  output logic                    o_bus_ack,
  output logic                    o_mem_en,
  output logic [AW-1:0]           o_mem_a,
  output logic [WORD_BYTES-1:0]   o_mem_we,
  output logic [8*WORD_BYTES-1:0] o_mem_di,
  input  logic [8*WORD_BYTES-1:0] i_mem_do
);

  localparam int PW = AW + LB;

  if (AW + LB > 8) begin : g_ptr_too_wide
    $error("byte_lane_ram_ctrl: AW+LB must not exceed 8");
  end

  ctrl_state_e           state;
  host_op_e              op_q;
  logic [PW-1:0]         ptr;
  logic [7:0]            rdata_q;
  logic                  rvalid_q;
  logic                  gnt_bus;
  logic                  gnt_host;
  host_op_e              op_in;
  logic [PW-1:0]         lane_sel;
  logic [AW-1:0]         ptr_word;
  logic [WORD_BYTES-1:0] lane_we;
  logic [7:0]            lane_byte;

  assign op_in    = host_op_e'(i_host_op);
  assign lane_sel = ptr & PW'(WORD_BYTES - 1);
  assign ptr_word = AW'(ptr >> LB);

  byte_lane_ram_arb u_arb (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_en       (state == ST_IDLE),
    .i_req_bus  (i_bus_cyc),
    .i_req_host (i_host_valid),
    .o_gnt_bus  (gnt_bus),
    .o_gnt_host (gnt_host)
  );

  always_comb begin
    lane_we   = '0;
    lane_byte = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane_sel == PW'(i)) begin
        lane_we[i] = 1'b1;
        lane_byte  = i_mem_do[8*i +: 8];
      end
    end
  end

  // Macro strobes are combinational from the grant so the access lands in the grant cycle.
  always_comb begin
    o_mem_en     = 1'b0;
    o_mem_a      = '0;
    o_mem_we     = '0;
    o_mem_di     = '0;
    o_host_ready = 1'b0;
    if (gnt_bus) begin
      o_mem_en = 1'b1;
      o_mem_a  = i_bus_adr;
      o_mem_we = i_bus_we ? i_bus_sel : '0;
      o_mem_di = i_bus_dat;
    end else if (gnt_host) begin
      o_host_ready = 1'b1;
      case (op_in)
        HOP_WRITE: begin
          o_mem_en = 1'b1;
          o_mem_a  = ptr_word;
          o_mem_we = lane_we;
          o_mem_di = {WORD_BYTES{i_host_data}};
        end
        HOP_READ: begin
          o_mem_en = 1'b1;
          o_mem_a  = ptr_word;
        end
        default: ;
      endcase
    end
  end

  // An ack in a reset cycle would belong to an abandoned access.
  assign o_bus_ack     = (state == ST_BUS_ACK) && !i_rst;
  assign o_bus_rdt     = o_bus_ack ? i_mem_do : '0;
  assign o_host_rdata  = rdata_q;
  assign o_host_rvalid = rvalid_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      op_q     <= HOP_NOP;
      ptr      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_bus) begin
            state <= ST_BUS_ACK;
          end else if (gnt_host) begin
            state <= ST_HOST_ACK;
            op_q  <= op_in;
            if (op_in == HOP_SETA) begin
              ptr <= i_host_data[PW-1:0];
            end
          end
        end
        ST_BUS_ACK: state <= ST_HOLD;
        ST_HOLD:    state <= ST_IDLE;
        ST_HOST_ACK: begin
          if (op_q == HOP_READ) begin
            rdata_q  <= lane_byte;
            rvalid_q <= 1'b1;
          end
`ifdef BYTE_LANE_RAM_CTRL_AUTOINC_EN
          if (op_q == HOP_WRITE || op_q == HOP_READ) begin
            ptr <= ptr + 1'b1;
          end
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_ram_ctrl.sv
// Self-checking bench for byte_lane_ram_ctrl: vector table for host grant-cycle strobes,
// scoreboard queues for read data, hand sequences for arbitration, HOLD and reset corners.
module tb_byte_lane_ram_ctrl;

  localparam int WB    = 4;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_host_valid;
  logic [1:0]  i_host_op;
  logic [7:0]  i_host_data;
  logic        o_host_ready;
  logic [7:0]  o_host_rdata;
  logic        o_host_rvalid;
  logic        i_bus_cyc;
  logic        i_bus_we;
  logic [4:0]  i_bus_adr;
  logic [3:0]  i_bus_sel;
  logic [31:0] i_bus_dat;
  logic [31:0] o_bus_rdt;
  logic        o_bus_ack;
  logic        o_mem_en;
  logic [4:0]  o_mem_a;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_di;
  logic [31:0] mem_do;

  byte_lane_ram_ctrl #(.WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_host_valid  (i_host_valid),
    .i_host_op     (i_host_op),
    .i_host_data   (i_host_data),
    .o_host_ready  (o_host_ready),
    .o_host_rdata  (o_host_rdata),
    .o_host_rvalid (o_host_rvalid),
    .i_bus_cyc     (i_bus_cyc),
    .i_bus_we      (i_bus_we),
    .i_bus_adr     (i_bus_adr),
    .i_bus_sel     (i_bus_sel),
    .i_bus_dat     (i_bus_dat),
    .o_bus_rdt     (o_bus_rdt),
    .o_bus_ack     (o_bus_ack),
    .o_mem_en      (o_mem_en),
    .o_mem_a       (o_mem_a),
    .o_mem_we      (o_mem_we),
    .o_mem_di      (o_mem_di),
    .i_mem_do      (mem_do)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model: registered read of the pre-write word, per-lane writes.
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin : macro
    logic [31:0] w;
    if (o_mem_en) begin
      w = sram[o_mem_a];
      mem_do <= w;
      for (int l = 0; l < WB; l++)
        if (o_mem_we[l]) w[8*l +: 8] = o_mem_di[8*l +: 8];
      sram[o_mem_a] <= w;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model
  logic [7:0] ref_mem [DEPTH*WB];
  logic [6:0] ref_ptr;

  function automatic logic [31:0] ref_word(input logic [4:0] a);
    return {ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}], ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]};
  endfunction

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } hexp_t;
  hexp_t       hq[$];
  logic [31:0] bq[$];

  always @(negedge clk) begin : monitor
    hexp_t e;
    if (o_host_rvalid) begin
      if (hq.size() == 0) fail("rvalid_unexpected", 32'(o_host_rdata), 32'hx);
      else begin
        e = hq.pop_front();
        chk("host_rdata", 32'(o_host_rdata), 32'(e.data));
        chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (o_bus_ack && !i_bus_we) begin
      if (bq.size() == 0) fail("ack_unexpected", o_bus_rdt, 32'hx);
      else chk("bus_rdt", o_bus_rdt, bq.pop_front());
    end
  end

  logic        s_en;
  logic [4:0]  s_a;
  logic [3:0]  s_we;
  logic [31:0] s_di;

  task automatic host_op(input logic [1:0] op, input logic [7:0] data, output int rc);
    int n = 0;
    i_host_valid = 1'b1;
    i_host_op    = op;
    i_host_data  = data;
    do begin
      @(negedge clk);
      n++;
    end while (!o_host_ready && n < 50);
    rc = -1;
    if (!o_host_ready) fail("host_ready_timeout", 0, 1);
    else begin
      rc   = cyc;
      s_en = o_mem_en;
      s_a  = o_mem_a;
      s_we = o_mem_we;
      s_di = o_mem_di;
      case (op)
        2'd0: ref_ptr = data[6:0];
        2'd1: begin
          ref_mem[ref_ptr] = data;
`ifdef BYTE_LANE_RAM_CTRL_AUTOINC_EN
          ref_ptr = ref_ptr + 1'b1;
`endif
        end
        2'd2: begin
          hq.push_back('{data: ref_mem[ref_ptr], cyc: cyc + 2});
`ifdef BYTE_LANE_RAM_CTRL_AUTOINC_EN
          ref_ptr = ref_ptr + 1'b1;
`endif
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1 i_host_valid = 1'b0;
  endtask

  task automatic bus_op(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output int ac);
    int n = 0;
    i_bus_cyc = 1'b1;
    i_bus_we  = we;
    i_bus_adr = adr;
    i_bus_sel = sel;
    i_bus_dat = dat;
    if (!we) bq.push_back(ref_word(adr));
    do begin
      @(negedge clk);
      n++;
    end while (!o_bus_ack && n < 50);
    ac = -1;
    if (!o_bus_ack) fail("bus_ack_timeout", 0, 1);
    else begin
      ac = cyc;
      if (we)
        for (int l = 0; l < WB; l++)
          if (sel[l]) ref_mem[{adr, 2'(l)}] = dat[8*l +: 8];
    end
    @(posedge clk);
    #1;
    i_bus_cyc = 1'b0;
    i_bus_we  = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic        en;
    logic [4:0]  a;
    logic [3:0]  we;
    logic [31:0] di;
    logic        chk_di;
  } tv_t;
  tv_t tv[13];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hr, ba, t0;
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    for (int i = 0; i < DEPTH*WB; i++) ref_mem[i] = '0;
    ref_ptr = '0;
    mem_do  = '0;

    tv[0]  = '{2'd0, 8'h05, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[1]  = '{2'd1, 8'hAB, 1'b1, 5'd1,  4'b0010, 32'hABABABAB, 1'b1};
    tv[2]  = '{2'd0, 8'h7C, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[3]  = '{2'd1, 8'h11, 1'b1, 5'd31, 4'b0001, 32'h11111111, 1'b1};
    tv[4]  = '{2'd2, 8'h00, 1'b1, 5'd31, 4'b0000, 32'h0,        1'b0};
    tv[5]  = '{2'd3, 8'hFF, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[6]  = '{2'd0, 8'h03, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[7]  = '{2'd1, 8'hC3, 1'b1, 5'd0,  4'b1000, 32'hC3C3C3C3, 1'b1};
    tv[8]  = '{2'd0, 8'hFF, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[9]  = '{2'd1, 8'h5A, 1'b1, 5'd31, 4'b1000, 32'h5A5A5A5A, 1'b1};
`ifdef BYTE_LANE_RAM_CTRL_AUTOINC_EN
    tv[10] = '{2'd2, 8'h00, 1'b1, 5'd0,  4'b0000, 32'h0,        1'b0};
`else
    tv[10] = '{2'd2, 8'h00, 1'b1, 5'd31, 4'b0000, 32'h0,        1'b0};
`endif
    tv[11] = '{2'd0, 8'h05, 1'b0, 5'd0,  4'b0000, 32'h0,        1'b0};
    tv[12] = '{2'd2, 8'h00, 1'b1, 5'd1,  4'b0000, 32'h0,        1'b0};

    i_rst = 1'b1;
    i_host_valid = 1'b0; i_host_op = '0; i_host_data = '0;
    i_bus_cyc = 1'b0; i_bus_we = 1'b0; i_bus_adr = '0; i_bus_sel = '0; i_bus_dat = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", 32'(o_mem_en), 0);
    chk("rst_mem_we", 32'(o_mem_we), 0);
    chk("rst_bus_ack", 32'(o_bus_ack), 0);
    chk("rst_host_ready", 32'(o_host_ready), 0);
    chk("rst_rvalid", 32'(o_host_rvalid), 0);
    chk("rst_rdata", 32'(o_host_rdata), 0);
    chk("rst_bus_rdt", o_bus_rdt, 0);
    @(posedge clk);
    #1;

    // Tie right after reset: bus first, host after the bus HOLD cycle.
    fork
      bus_op(1'b1, 5'd3, 4'b1111, 32'h11223344, ba);
      host_op(2'd0, 8'h0E, hr);
    join
    chk("tie1_host_after_bus", 32'(hr), 32'(ba + 2));

    // Bus granted last, so the next tie goes to the host.
    bus_op(1'b0, 5'd3, 4'b0000, 32'h0, ba);
    fork
      bus_op(1'b0, 5'd3, 4'b0000, 32'h0, ba);
      host_op(2'd2, 8'h00, hr);
    join
    chk("tie2_bus_after_host", 32'(ba), 32'(hr + 3));

    // Bus read then HOLD: no grant even with the host requesting.
    bus_op(1'b0, 5'd3, 4'b0000, 32'h0, ba);
    i_host_valid = 1'b1;
    i_host_op    = 2'd3;
    @(negedge clk);
    chk("hold_ack", 32'(o_bus_ack), 0);
    chk("hold_mem_en", 32'(o_mem_en), 0);
    chk("hold_host_ready", 32'(o_host_ready), 0);
    chk("hold_bus_rdt", o_bus_rdt, 0);
    @(negedge clk);
    chk("idle_after_hold_ready", 32'(o_host_ready), 1);
    @(posedge clk);
    #1 i_host_valid = 1'b0;

    for (int i = 0; i < 13; i++) begin
      host_op(tv[i].op, tv[i].data, hr);
      chk($sformatf("tv%0d_mem_en", i), 32'(s_en), 32'(tv[i].en));
      chk($sformatf("tv%0d_mem_we", i), 32'(s_we), 32'(tv[i].we));
      if (tv[i].en) chk($sformatf("tv%0d_mem_a", i), 32'(s_a), 32'(tv[i].a));
      if (tv[i].chk_di) chk($sformatf("tv%0d_mem_di", i), s_di, tv[i].di);
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_rdata", 32'(o_host_rdata), 32'hAB);

    // Reset during BUS_ACK: access abandoned, state/ptr/rdata cleared.
    @(posedge clk);
    #1;
    i_bus_cyc = 1'b1;
    i_bus_we  = 1'b0;
    i_bus_adr = 5'd3;
    t0 = 0;
    do begin
      @(negedge clk);
      t0++;
    end while (!o_mem_en && t0 < 20);
    if (!o_mem_en) fail("rst_seq_grant_timeout", 0, 1);
    @(posedge clk);
    #1 i_rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ack_no_ack", 32'(o_bus_ack), 0);
    @(posedge clk);
    #1;
    i_rst     = 1'b0;
    i_bus_cyc = 1'b0;
    ref_ptr   = '0;
    @(negedge clk);
    chk("post_rst_rdata", 32'(o_host_rdata), 0);
    chk("post_rst_ack", 32'(o_bus_ack), 0);
    chk("post_rst_rvalid", 32'(o_host_rvalid), 0);
    @(posedge clk);
    #1 t0 = cyc;
    host_op(2'd2, 8'h00, hr);
    chk("post_rst_idle_grant", 32'(hr), 32'(t0));
    chk("post_rst_ptr_word", 32'(s_a), 0);
    chk("post_rst_read_en", 32'(s_en), 1);

    repeat (5) @(negedge clk);
    chk("host_queue_drained", 32'(hq.size()), 0);
    chk("bus_queue_drained", 32'(bq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_lane_ram_ctrl.md
# byte_lane_ram_ctrl

Parametrised front-end for a word-wide, byte-write-enabled SRAM macro (RAM32 class). It arbitrates between two requesters: a byte-serial host port driven from the chip pins, and a Wishbone-style CPU bus (SERV ibus/dbus after external muxing). It generates per-lane write enables, selects byte lanes on read, and keeps an auto-incrementing host byte pointer. It sits between the top-level pin wrapper / SERV core and the SRAM macro.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per SRAM word; power of two, 1..8.
- DEPTH, 32, words in the macro; power of two.
- AW, $clog2(DEPTH), word address width (derived).
- LB, $clog2(WORD_BYTES), byte-lane select width (derived); AW+LB ≤ 8 is enforced by an elaboration check.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_host_valid  in  1  host op request; held until o_host_ready.
- i_host_op  in  2  0=SETA, 1=WRITE, 2=READ, 3=NOP.
- i_host_data  in  8  pointer value (SETA) or write byte.
- o_host_ready  out  1  op accepted this cycle.
- o_host_rdata  out  8  last read byte, held.
- o_host_rvalid  out  1  one-cycle pulse when o_host_rdata updates.
- i_bus_cyc, i_bus_we  in  1  bus request / write.
- i_bus_adr  in  AW  word address.
- i_bus_sel  in  WORD_BYTES  byte enables.
- i_bus_dat  in  8*WORD_BYTES  write data.
- o_bus_rdt  out  8*WORD_BYTES  read data.
- o_bus_ack  out  1  one-cycle completion pulse.
- o_mem_en  out  1  macro enable.
- o_mem_a  out  AW  macro address.
- o_mem_we  out  WORD_BYTES  macro lane write enables.
- o_mem_di  out  8*WORD_BYTES  macro write data.
- i_mem_do  in  8*WORD_BYTES  macro read data, valid one cycle after en.

## Operation
- FSM: IDLE, BUS_ACK, HOST_ACK, HOLD.
- IDLE: if both request, grant the one not granted last (last_grant register; reset = HOST, so the bus wins the first tie). Grant drives o_mem_en=1, o_mem_a, o_mem_we, o_mem_di in the same cycle.
- Bus grant: o_mem_a=i_bus_adr; o_mem_we=i_bus_we ? i_bus_sel : 0; o_mem_di=i_bus_dat; go to BUS_ACK.
- BUS_ACK: o_bus_ack=1, o_bus_rdt=i_mem_do (pass-through); go to HOLD.
- HOLD: one dead cycle so the requester can drop cyc; bus ignored, then IDLE.
- Host grant: o_host_ready=1 in the grant cycle; go to HOST_ACK. Ptr = {word, lane}, AW+LB bits.
  - SETA: ptr ← i_host_data[AW+LB-1:0]; o_mem_en=0.
  - WRITE: o_mem_a=ptr word; o_mem_we=one-hot(ptr lane); o_mem_di=i_host_data replicated to every lane.
  - READ: o_mem_a=ptr word; o_mem_we=0.
  - NOP: accepted, no memory access.
- HOST_ACK: on READ, o_host_rdata ← i_mem_do lane ptr at the clock edge ending this cycle; o_host_rvalid pulses the next cycle. Pointer update per Configuration. Then IDLE; the host needs no dead cycle.
- Outputs not driven by the current state are 0: o_mem_en, o_mem_we, o_bus_ack, o_host_ready, o_host_rvalid. o_bus_rdt is 0 outside BUS_ACK.

## Timing
- Reset: state=IDLE, ptr=0, last_grant=HOST, o_host_rdata=0. All strobes are 0 in the first cycle after reset.
- Bus: grant at T, ack at T+1. Next bus grant no earlier than T+3.
- Host: ready at T. WRITE is committed at the T edge. READ gives rvalid at T+2. Next host grant no earlier than T+2.
- Reset asserted during an access: the access is abandoned and no ack or rvalid is issued. A write whose grant cycle coincides with the reset cycle still reaches the macro; this is accepted.
- Pointer wrap: DEPTH*WORD_BYTES-1 → 0.
- A request that drops before it is granted is simply lost; no error is raised.

## Configuration
- BYTE_LANE_RAM_CTRL_AUTOINC_EN defined: after each WRITE or READ, ptr increments by 1 (mod DEPTH*WORD_BYTES) in HOST_ACK.
- Undefined: ptr changes only on SETA and reset. WRITE and READ leave it unchanged.

## Structure
- Package byte_lane_ram_pkg holds:
  - host op encodings (HOP_SETA, HOP_WRITE, HOP_READ, HOP_NOP);
  - the FSM state enum;
  - a grant-owner enum (OWN_BUS, OWN_HOST).
- One sub-module, byte_lane_ram_arb: a two-requester round-robin arbiter with a last_grant register.
- Lane decode and lane mux stay inline.

## Test plan
All scenarios use the default parameters (WORD_BYTES=4, DEPTH=32).
- Host SETA 0x05; WRITE 0xAB → o_mem_a=1, o_mem_we=0b0010, o_mem_di=0xABABABAB. With AUTOINC, ptr=0x06.
- Bus write adr=3, sel=0b1111, dat=0x11223344; host SETA 0x0E; READ → o_host_rdata=0x22, with rvalid at T+2.
- Host and bus request in the same cycle right after reset → bus granted first, host granted next, then the two alternate.
- AUTOINC: SETA 0x7F; WRITE 0x5A; READ → the read returns the byte at 0x00 and ptr=0x01 (wrap).
- Bus read: o_bus_ack is exactly 1 cycle, the following cycle is HOLD with no grant, and the value matches the earlier write.
- i_rst asserted during BUS_ACK → no ack, state=IDLE, ptr=0, o_host_rdata=0 next cycle.
